// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait timeout, fault halt and perf counters
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             addr_sel_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_sel_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_write_o,
    output logic [1:0]       wb_sel_o,
    output logic [2:0]       state_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic [CNT_W-1:0] instret_o
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycles_q, instret_q;
    logic              illegal_q, bus_err_q;
    logic              retire, set_ill, set_be, timeout, legal, is_ld, is_st;

    assign is_ld   = opcode_i == OP_LD;
    assign is_st   = opcode_i == OP_ST;
    assign legal   = opcode_i inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
    assign timeout = (MAX_WAIT != 0) && (wait_q == LAST_WAIT);

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;
    assign cycles_o  = cycles_q;
    assign instret_o = instret_q;

    // Next state, wait count and control outputs; every control is held low during reset
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        retire      = 1'b0;
        set_ill     = 1'b0;
        set_be      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        addr_sel_o  = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_sel_o    = 2'd0;
        alu_src_a_o = 2'd0;
        alu_src_b_o = 2'd0;
        alu_op_o    = 2'b00;
        reg_write_o = 1'b0;
        wb_sel_o    = 2'd0;
        if (rst_ni) begin
            case (state_q)
                FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'd1;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                    wait_d      = mem_ready_i ? '0 : wait_q + WAIT_W'(1);
                    set_be      = !mem_ready_i && timeout;
                    state_d     = mem_ready_i ? DECODE : (timeout ? HALT : FETCH);
                end
                DECODE: begin
                    alu_src_a_o = 2'd1;
                    alu_src_b_o = 2'd2;
                    set_ill     = !legal;
                    state_d     = legal ? EXEC : HALT;
                end
                EXEC: begin
                    case (opcode_i)
                        OP_R: begin
                            alu_src_a_o = 2'd2;
                            alu_op_o    = 2'b10;
                            state_d     = WB;
                        end
                        OP_I: begin
                            alu_src_a_o = 2'd2;
                            alu_src_b_o = 2'd2;
                            alu_op_o    = 2'b10;
                            state_d     = WB;
                        end
                        OP_LD, OP_ST: begin
                            alu_src_a_o = 2'd2;
                            alu_src_b_o = 2'd2;
                            state_d     = MEM;
                        end
                        OP_BR: begin
                            alu_src_a_o = 2'd2;
                            alu_op_o    = 2'b01;
                            pc_write_o  = zero_i ^ funct3_i[0];
                            pc_sel_o    = 2'd1;
                            retire      = 1'b1;
                            state_d     = FETCH;
                        end
                        OP_JAL: begin
                            pc_write_o  = 1'b1;
                            pc_sel_o    = 2'd1;
                            reg_write_o = 1'b1;
                            wb_sel_o    = 2'd2;
                            retire      = 1'b1;
                            state_d     = FETCH;
                        end
                        OP_JALR: begin
                            alu_src_a_o = 2'd2;
                            alu_src_b_o = 2'd2;
                            pc_write_o  = 1'b1;
                            pc_sel_o    = 2'd2;
                            reg_write_o = 1'b1;
                            wb_sel_o    = 2'd2;
                            retire      = 1'b1;
                            state_d     = FETCH;
                        end
                        default: begin
                            set_ill = 1'b1;
                            state_d = HALT;
                        end
                    endcase
                end
                MEM: begin
                    mem_req_o  = 1'b1;
                    addr_sel_o = 1'b1;
                    mem_we_o   = is_st;
                    retire     = mem_ready_i && is_st;
                    wait_d     = mem_ready_i ? '0 : wait_q + WAIT_W'(1);
                    set_be     = !mem_ready_i && timeout;
                    state_d    = mem_ready_i ? (is_st ? FETCH : WB) : (timeout ? HALT : MEM);
                end
                WB: begin
                    reg_write_o = 1'b1;
                    wb_sel_o    = is_ld ? 2'd1 : 2'd0;
                    retire      = 1'b1;
                    state_d     = FETCH;
                end
                HALT: state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    // State, wait counter, sticky fault flags and wrapping performance counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            cycles_q  <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            if (state_q != HALT) cycles_q <= cycles_q + CNT_W'(1);
            if (retire) instret_q <= instret_q + CNT_W'(1);
            illegal_q <= illegal_q | set_ill;
            bus_err_q <= bus_err_q | set_be;
        end
    end
endmodule
